// File: rtl/rv32_lsu_pkg.sv
// rv32_lsu_pkg: shared definitions for the RV32I load/store initiator.
//   - funct3 width/sign codes for loads and stores
//   - LSU state encoding
//   - default memory response timeout
//   - f3_legal(): whether a funct3 value is a legal load or store code
package rv32_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational lane select and extension of a RAM read word.
//   i_rdata    [31:0] raw word from the data RAM
//   i_byte_off [1:0]  byte offset of the access (addr[1:0])
//   i_funct3   [2:0]  load width/sign code
//   o_ldata    [31:0] sign/zero-extended load result
// Half loads select the lane with i_byte_off[1] only, so a misaligned half
// is aligned down; LW and any unknown code pass the word through.
module lsu_load_align
  import rv32_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_byte_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[8*i_byte_off +: 8];
    w_half = i_byte_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_LB:   o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_ldata = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_ldata = {24'd0, w_byte};
      F3_LHU:  o_ldata = {16'd0, w_half};
      default: o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the RV32I execute stage and a
// word-addressed data RAM with a registered valid response.
// Parameters: ADDR_W (RAM word-address width), TIMEOUT (max WAIT cycles).
// Ports:
//   clk, rst (async, active-low)
//   core side: i_start, i_is_store, i_funct3, i_addr, i_store_data
//              o_busy, o_done, o_err, o_load_data
//   RAM side:  o_mem_request, o_mem_w_en, o_mem_address, o_mem_write_data,
//              o_mem_masking, i_mem_valid, i_mem_read_data
// Build option: LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses
// with err; without it they are aligned down and issued normally.
module lsu_mem_master
  import rv32_lsu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_is_store,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_store_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_load_data,
  output logic              o_mem_request,
  output logic              o_mem_w_en,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [31:0]       o_mem_write_data,
  output logic [3:0]        o_mem_masking,
  input  logic              i_mem_valid,
  input  logic [31:0]       i_mem_read_data
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [1:0]        r_byte_off;
  logic              r_err;
  logic [31:0]       r_load_data;
  logic [ADDR_W-1:0] r_mem_address;
  logic [31:0]       r_mem_write_data;
  logic [3:0]        r_mem_masking;

  logic        w_can_accept, w_f3_ok, w_misalign, w_accept_ok, w_accept_rej;
  logic        w_timeout, w_in_flight;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata, w_load_ext;
  logic        w_unused_addr;

  assign w_unused_addr = ^i_addr[31:ADDR_W+2];

  // A new access is only sampled while nothing is in flight.
  assign w_can_accept = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_f3_ok      = f3_legal(i_is_store, i_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (i_funct3[1:0])
      2'b01:   w_misalign = i_addr[0];
      2'b10:   w_misalign = |i_addr[1:0];
      default: w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept_ok  = w_can_accept && w_f3_ok && !w_misalign;
  assign w_accept_rej = w_can_accept && !(w_f3_ok && !w_misalign);
  assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT));
  assign w_in_flight  = (r_state == ST_REQ) || (r_state == ST_WAIT);

  // funct3[1:0] encodes the access width for both loads and stores.
  always_comb begin
    case (i_funct3[1:0])
      2'b00: begin
        w_mask  = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        w_mask  = 4'b0011 << {i_addr[1], 1'b0};
        w_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        w_mask  = 4'b1111;
        w_wdata = i_store_data;
      end
    endcase
  end

  lsu_load_align u_align (
    .i_rdata    (i_mem_read_data),
    .i_byte_off (r_byte_off),
    .i_funct3   (r_funct3),
    .o_ldata    (w_load_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept_ok)       w_state_nxt = ST_REQ;
        else if (w_accept_rej) w_state_nxt = ST_DONE;
        else                   w_state_nxt = ST_IDLE;
      end
      ST_REQ:  w_state_nxt = i_mem_valid ? ST_DONE : ST_WAIT;
      ST_WAIT: if (i_mem_valid || w_timeout) w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt            <= '0;
      r_is_store       <= 1'b0;
      r_funct3         <= '0;
      r_byte_off       <= '0;
      r_err            <= 1'b0;
      r_load_data      <= '0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mem_masking    <= '0;
    end else begin
      if (w_accept_ok) begin
        r_is_store       <= i_is_store;
        r_funct3         <= i_funct3;
        r_byte_off       <= i_addr[1:0];
        r_err            <= 1'b0;
        r_mem_address    <= i_addr[ADDR_W+1:2];
        r_mem_write_data <= w_wdata;
        r_mem_masking    <= w_mask;
      end else if (w_accept_rej) begin
        r_err <= 1'b1;
        if (!i_is_store) r_load_data <= '0;
      end

      if (r_state == ST_REQ) r_cnt <= '0;

      // Stores leave load_data untouched; a timeout always clears it.
      if (w_in_flight && i_mem_valid) begin
        if (!r_is_store) r_load_data <= w_load_ext;
      end else if (r_state == ST_WAIT) begin
        if (w_timeout) begin
          r_err       <= 1'b1;
          r_load_data <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_busy           = w_in_flight;
  assign o_done           = (r_state == ST_DONE);
  assign o_err            = r_err && (r_state == ST_DONE);
  assign o_load_data      = r_load_data;
  assign o_mem_request    = (r_state == ST_REQ);
  assign o_mem_w_en       = r_is_store && w_in_flight;
  assign o_mem_address    = r_mem_address;
  assign o_mem_write_data = r_mem_write_data;
  assign o_mem_masking    = r_mem_masking;

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator between the RV32I execute stage and the word-addressed data RAM wrapper. It accepts one load or store per handshake from the core and builds the RAM request: word address, per-byte write masking and lane-replicated write data. It waits for the RAM's registered `valid`, then returns sign- or zero-extended load data with a one-cycle `done` pulse. Misaligned accesses, illegal `funct3` values and unresponsive memory are reported through `err`.

## Interface
- `ADDR_W`, 8, RAM word-address width; `mem_address` = `addr[ADDR_W+1:2]`
- `TIMEOUT`, 15, maximum cycles spent in WAIT before the access is aborted with `err`
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: access request from core; sampled only when `busy`=0
- `is_store` in 1: 1 = store, 0 = load
- `funct3` in 3: RV32I width/sign code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2)
- `addr` in 32: byte address
- `store_data` in 32: store source; low byte/half used for SB/SH
- `busy` out 1: access in flight (REQ or WAIT)
- `done` out 1: one-cycle completion pulse
- `err` out 1: valid with `done`; illegal `funct3`, misalignment, or timeout
- `load_data` out 32: extended load result; valid with `done`, held until next `done`
- `mem_request` out 1: one-cycle request pulse to RAM
- `mem_w_en` out 1: write enable, held from REQ until completion
- `mem_address` out `ADDR_W`: word address
- `mem_write_data` out 32: lane-replicated store data
- `mem_masking` out 4: byte enables
- `mem_valid` in 1: RAM response, registered copy of `mem_request`
- `mem_read_data` in 32: RAM read word, sampled when `mem_valid`=1

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE/DONE** accept `start`:
  - Legal access → REQ. Access fields are registered.
  - Rejected access (illegal `funct3`, or misaligned with the macro enabled) → DONE with `err`=1. No `mem_request` is issued.
  - No `start` → IDLE.
- **REQ**:
  - `mem_request`=1 for this cycle only.
  - `mem_valid` seen in REQ → DONE.
  - Otherwise → WAIT, with the wait counter cleared.
- **WAIT**:
  - `mem_valid` → DONE, capturing the extended read data.
  - Counter reaching `TIMEOUT` → DONE with `err`=1 and `load_data`=0.
- **DONE**: `done`=1 for exactly one cycle, then IDLE, or REQ if a new `start` is accepted.
- Legal `funct3`:
  - Loads: 0, 1, 2, 4, 5.
  - Stores: 0, 1, 2. Any other value is illegal.
- Masking:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << {addr[1],1'b0}`.
  - Word: `4'b1111`.
  - The same mask is driven for loads.
- Write data:
  - SB: `store_data[7:0]` replicated ×4.
  - SH: `store_data[15:0]` replicated ×2.
  - SW: `store_data` unchanged.
- Load extraction:
  - Byte lane selected by `addr[1:0]`; half lane selected by `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- For stores, `load_data` keeps its previous value.
- `mem_valid` arriving in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, counter 0, and every output 0 (`busy`, `done`, `err`, `load_data`, `mem_request`, `mem_w_en`, `mem_address`, `mem_write_data`, `mem_masking`).
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- Nominal latency, with `start` in cycle 0:
  - `mem_request` in cycle 1.
  - `mem_valid` in cycle 2.
  - `done` in cycle 3.
- Throughput: back-to-back `start` in the DONE cycle gives one access per 3 cycles.
- A rejected access gives `done`+`err` in cycle 1.
- Timeout: `done` arrives no later than cycle `TIMEOUT`+3.
- Reset asserted mid-access: the FSM returns to IDLE immediately, and no `done` is produced for the aborted access.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned half (`addr[0]`=1) is rejected with `err`.
  - Misaligned word (`addr[1:0]`≠0) is rejected with `err`.
- Undefined: misaligned accesses are silently aligned down:
  - Half ignores `addr[0]`.
  - Word ignores `addr[1:0]`.
  - Such accesses are issued to memory and `err` stays 0.

## Structure
- Package `rv32_lsu_pkg` holds:
  - `funct3` constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - The state enum type.
  - A default `TIMEOUT` constant.
- Sub-module `lsu_load_align` (combinational) takes `mem_read_data`, `addr[1:0]` and `funct3`, and produces the extended 32-bit load value.

## Test plan
- Each bullet gives the stimulus, then the required response.
- SW to `addr`=0x10 with `store_data`=0xDEADBEEF, then LW from 0x10:
  - Store: `mem_address`=0x04, `mem_masking`=1111.
  - Load: `done` in cycle 3 with `load_data`=0xDEADBEEF and `err`=0.
- SB 0xA5 to 0x13, then LB 0x13 and LBU 0x13:
  - Store: mask 1000, `mem_write_data`=0xA5A5A5A5.
  - Loads: 0xFFFFFFA5 and 0x000000A5.
- SH 0x8001 to 0x22, then LH 0x22 and LHU 0x22:
  - Store: mask 1100.
  - Loads: 0xFFFF8001 and 0x00008001.
- LW at 0x11:
  - With the macro: `done`+`err` in cycle 1, no `mem_request`.
  - Without the macro: the access reads word 0x04 with `err`=0.
- Load with `funct3`=3, and a memory model that holds `mem_valid` low:
  - Illegal `funct3`: immediate `err`.
  - Stalled memory: `err`=1, `load_data`=0, `done` at cycle `TIMEOUT`+3.
- `rst` dropped in WAIT, and `start` pulsed while `busy`=1:
  - Reset: all outputs 0 and no `done` for the aborted access.
  - `start` while busy is ignored, and the in-flight access completes unchanged.
